bcd_to_bin_seq: RTL
===================

// Module: bcd_to_bin_seq
// PURPOSE
//  Sequential packed-BCD to binary converter; inverse of the binary-to-BCD display decoder.
//  Takes DIGITS packed BCD digits (e.g. switch/keypad entry) and returns the unsigned binary value.
//  Processes one digit per cycle, MS digit first: acc = acc*10 + digit.
//  Valid/ready handshake on input and output; sits between digit-entry logic and the arithmetic datapath.
// PARAMETERS
//  DIGITS  2  number of BCD digits in bcd_in (>=1)
//  BIN_W   7  width of bin_out; must satisfy 2**BIN_W > 10**DIGITS-1 (elaboration-time $error otherwise)
// PORTS
//  clk        in   1           single clock, rising edge
//  rst_n      in   1           asynchronous, active-low reset
//  in_valid   in   1           bcd_in valid
//  in_ready   out  1           converter idle, can accept
//  bcd_in     in   4*DIGITS    packed BCD, digit DIGITS-1 in MS nibble
//  out_valid  out  1           bin_out/err valid
//  out_ready  in   1           consumer accepts result
//  bin_out    out  BIN_W       unsigned binary result
//  err        out  1           some input nibble > 9
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE, in_ready=1, out_valid=0, bin_out=0, err=0, acc=0, cnt=0.
//    Reset asserted mid-conversion aborts it; no result is produced for the accepted word.
//  - FSM states: IDLE, CONV, DONE.
//  - IDLE: in_ready=1. On in_valid&&in_ready at edge E0: capture bcd_in into shift reg,
//    acc<=0, cnt<=0, err_q<=(any nibble>4'd9); go CONV.
//  - CONV: in_ready=0. Each edge: acc<=acc*10+top nibble (acc*10 = (acc<<3)+(acc<<1),
//    computed at BIN_W+4 bits then truncated to BIN_W), shift reg <<4, cnt++.
//    At the edge where cnt==DIGITS-1 is processed (edge E_DIGITS) go DONE.
//  - DONE: out_valid=1; bin_out=acc, or 0 if err_q; err=err_q. bin_out/err stable while
//    out_valid&&!out_ready. On out_valid&&out_ready: go IDLE, out_valid<=0.
//  - Latency: out_valid high DIGITS cycles after accept edge. Throughput: one word per
//    DIGITS+2 cycles minimum (no accept during the DONE handshake cycle).
//  - in_valid while in_ready=0 is ignored; bcd_in changes after accept have no effect.
//  - out_ready while out_valid=0 is ignored.
//  - Invalid nibbles (A-F) still run through CONV (fixed latency); result forced to 0 with err=1.
//  - Overflow impossible under the BIN_W constraint; no saturation logic.
// STRUCTURE
//  - Package bcd_pkg: typedef enum logic [1:0] {S_IDLE, S_CONV, S_DONE} bcd_state_t;
//    localparam logic [3:0] BCD_MAX = 4'd9; function is_bcd(logic [3:0]).
//  - Sub-module bcd_mac10 (combinational): acc_i[BIN_W], digit_i[4] -> acc_o[BIN_W] = acc_i*10+digit_i.
//  - Top holds FSM, shift register, cnt ($clog2(DIGITS+1) bits), acc, err_q.
// TESTING
//  - Reset then bcd_in=8'h42, in_valid 1 cycle -> out_valid after 2 cycles, bin_out=7'd42, err=0.
//  - Sweep 8'h00..8'h99 (all valid) with out_ready=1 -> bin_out equals decimal value each word.
//  - bcd_in=8'h1A -> out_valid after 2 cycles, err=1, bin_out=0; next 8'h07 -> 7, err=0.
//  - 8'h99, out_ready=0 for 5 cycles -> out_valid, bin_out=99 held stable; in_ready=0 throughout;
//    out_ready=1 -> in_ready=1 next cycle.
//  - Accept 8'h55, pull rst_n=0 mid-CONV -> all outputs 0 immediately, in_ready=1 after release,
//    no out_valid for 8'h55; then 8'h31 -> 31.
//  - in_valid held with changing bcd_in during CONV/DONE -> ignored; only the captured word reported.

Source files
------------

// File: rtl/bcd_pkg.sv
// bcd_pkg: shared state type, digit limit and digit-validity helper for the BCD-to-binary converter
package bcd_pkg;

   typedef enum logic [1:0] {S_IDLE, S_CONV, S_DONE} bcd_state_t;

   localparam logic [3:0] BCD_MAX = 4'd9;

   function automatic logic is_bcd(logic [3:0] nib);
      return nib <= BCD_MAX;
   endfunction

endpackage

// File: rtl/bcd_mac10.sv
// bcd_mac10: combinational acc*10 + digit, evaluated at BIN_W+4 bits then truncated
module bcd_mac10 #(
   parameter int BIN_W = 7
) (
   input  logic [BIN_W-1:0] acc_i,
   input  logic [3:0]       digit_i,
   output logic [BIN_W-1:0] acc_o
);

   logic [BIN_W+3:0] wide;
   logic [BIN_W+3:0] prod;

   // times ten as (x<<3)+(x<<1), widened so the shifts lose nothing before truncation
   always_comb begin
      wide  = {4'd0, acc_i};
      prod  = (wide << 3) + (wide << 1) + {{BIN_W{1'b0}}, digit_i};
      acc_o = prod[BIN_W-1:0];
   end

endmodule

// File: rtl/bcd_to_bin_seq.sv
// bcd_to_bin_seq: sequential packed-BCD to binary converter, one digit per cycle, MS digit first
module bcd_to_bin_seq
   import bcd_pkg::*;
#(
   parameter int DIGITS = 2,
   parameter int BIN_W  = 7
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [4*DIGITS-1:0]   bcd_in,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [BIN_W-1:0]      bin_out,
   output logic                  err
);

   localparam int CW = $clog2(DIGITS + 1);
   localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

   if (DIGITS < 1) begin : g_chk_digits
      $error("bcd_to_bin_seq: DIGITS must be at least 1");
   end
   if ((2.0 ** BIN_W) <= (10.0 ** DIGITS - 1.0)) begin : g_chk_width
      $error("bcd_to_bin_seq: BIN_W too narrow for DIGITS decimal digits");
   end

   bcd_state_t           state_q;
   logic [4*DIGITS-1:0]  sh_q;
   logic [BIN_W-1:0]     acc_q;
   logic [BIN_W-1:0]     acc_d;
   logic [CW-1:0]        cnt_q;
   logic                 err_q;
   logic                 bad_d;
   logic                 in_ready_q;
   logic                 out_valid_q;
   logic [BIN_W-1:0]     bin_q;

   bcd_mac10 #(.BIN_W(BIN_W)) u_mac (
      .acc_i   (acc_q),
      .digit_i (sh_q[4*DIGITS-1 -: 4]),
      .acc_o   (acc_d)
   );

   // flag the word as invalid if any nibble lies above nine
   always_comb begin
      bad_d = 1'b0;
      for (int i = 0; i < DIGITS; i++) bad_d = bad_d | ~is_bcd(bcd_in[4*i +: 4]);
   end

   // control FSM with datapath registers; outputs are registered and change only on transitions
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         sh_q        <= '0;
         acc_q       <= '0;
         cnt_q       <= '0;
         err_q       <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         bin_q       <= '0;
      end else begin
         case (state_q)
            S_IDLE: if (in_valid) begin
               sh_q       <= bcd_in;
               acc_q      <= '0;
               cnt_q      <= '0;
               err_q      <= bad_d;
               in_ready_q <= 1'b0;
               state_q    <= S_CONV;
            end
            S_CONV: begin
               acc_q <= acc_d;
               sh_q  <= sh_q << 4;
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == LAST) begin
                  out_valid_q <= 1'b1;
                  bin_q       <= err_q ? '0 : acc_d;
                  state_q     <= S_DONE;
               end
            end
            S_DONE: if (out_ready) begin
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
               state_q     <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign bin_out   = bin_q;
   assign err       = err_q;

endmodule
